// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared definitions for the store buffer slice.
//   SB_DEPTH   : default number of pending-store entries
//   TAG_W      : word-address tag width (byte address bits [31:2])
//   sb_entry_t : one pending store {tag, data}
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int TAG_W    = 30;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match
// DEPTH-way tag compare over the pending stores with youngest-first
// priority, used for store-to-load forwarding.
// Ports:
//   entries : entry storage array, indexed by physical slot
//   head    : slot of the oldest pending entry
//   count   : number of pending entries (0..DEPTH)
//   ld_tag  : load word address (byte address bits [31:2])
//   hit     : some pending entry matches ld_tag
//   data    : data of the youngest matching entry, 0 when no hit
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [PTR_W-1:0]   head,
    input  logic [CNT_W-1:0]   count,
    input  logic [TAG_W-1:0]   ld_tag,
    output logic               hit,
    output logic [31:0]        data
);

    logic [PTR_W-1:0] idx;

    // Walk entries from oldest to youngest; a later match overwrites an
    // earlier one, so the youngest matching store wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].tag == ld_tag)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Circular FIFO of pending word stores that drains in program order to
// data memory, with optional store-to-load forwarding.
// Build option: define STORE_BUFFER_FWD_EN to compile in forwarding;
// otherwise ld_hit/ld_data are tied to 0.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   st_valid/st_ready  : CPU store handshake; st_addr/st_data the store
//   ld_addr            : load address checked for forwarding
//   ld_hit/ld_data     : forwarding result
//   dm_stall           : data memory cannot take a write this cycle
//   dm_addr/dm_wd/dm_we: write port to data memory (head entry)
//   empty/full         : occupancy flags
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    input  logic        dm_stall,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    output logic        empty,
    output logic        full
);

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Word stores only: the byte-offset bits carry no information.
    logic unused_addr_bits;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // No bypass when full: a drain this cycle does not free a slot for a
    // store until the next cycle.
    assign st_ready = !full;
    assign push     = st_valid && st_ready;
    assign dm_we    = !empty && !dm_stall;
    assign pop      = dm_we;

    assign dm_addr  = empty ? 32'd0 : {mem[head].tag, 2'b00};
    assign dm_wd    = empty ? 32'd0 : mem[head].data;

    // Pointers and occupancy; power-of-two DEPTH lets the pointers wrap
    // naturally at their width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; validity comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail].tag  <= st_addr[31:2];
            mem[tail].data <= st_data;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (mem),
        .head    (head),
        .count   (count),
        .ld_tag  (ld_addr[31:2]),
        .hit     (ld_hit),
        .data    (ld_data)
    );

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};
`else
    assign ld_hit  = 1'b0;
    assign ld_data = 32'd0;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
// Directed bench for store_buffer (DEPTH=4). Forwarding expectations
// follow STORE_BUFFER_FWD_EN so the same bench serves both builds.
module tb_store_buffer;

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_stall;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic        empty;
    logic        full;

    int tests_run;
    int tests_failed;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .dm_stall (dm_stall),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_we    (dm_we),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle briefly so
    // the caller can sample combinational outputs before the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] a,
                                 input logic [31:0] d, input logic stall,
                                 input logic [31:0] la);
        @(negedge clk);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        dm_stall = stall;
        ld_addr  = la;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        dm_stall = 1'b0;
        ld_addr  = '0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'h10);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
        checkOutput("rst_dm_we", 32'(dm_we), 32'd0);
        checkOutput("rst_dm_addr", dm_addr, 32'd0);
        checkOutput("rst_dm_wd", dm_wd, 32'd0);
        checkOutput("rst_ld_hit", 32'(ld_hit), 32'd0);
        checkOutput("rst_ld_data", ld_data, 32'd0);
        reset = 1'b0;

        // Single store drains the cycle after acceptance
        applyStimulus(1, 32'h10, 32'hAAAA0001, 0, 0);
        checkOutput("t1_st_ready", 32'(st_ready), 32'd1);
        checkOutput("t1_dm_we_pre", 32'(dm_we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_dm_we", 32'(dm_we), 32'd1);
        checkOutput("t1_dm_addr", dm_addr, 32'h10);
        checkOutput("t1_dm_wd", dm_wd, 32'hAAAA0001);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_empty", 32'(empty), 32'd1);
        checkOutput("t1_dm_we_post", 32'(dm_we), 32'd0);

        // Five stores under stall: four accepted, fifth refused
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h100 + 32'(4 * i), 32'h100 + 32'(i), 1, 0);
            checkOutput($sformatf("t2_st_ready_%0d", i), 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        checkOutput("t2_full", 32'(full), 32'd1);
        checkOutput("t2_dm_we_stalled", 32'(dm_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("t2_dm_we_%0d", i), 32'(dm_we), 32'd1);
            checkOutput($sformatf("t2_dm_addr_%0d", i), dm_addr, 32'h100 + 32'(4 * i));
            checkOutput($sformatf("t2_dm_wd_%0d", i), dm_wd, 32'h100 + 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_empty", 32'(empty), 32'd1);

        // Forwarding: youngest match wins, in-flight enqueue not visible
        applyStimulus(1, 32'h20, 32'd1, 1, 32'h20);
        checkOutput("t3_hit_empty", 32'(ld_hit), 32'd0);
        applyStimulus(1, 32'h20, 32'd2, 1, 32'h20);
        checkOutput("t3_hit_one", 32'(ld_hit), 32'(FWD));
        checkOutput("t3_data_one", ld_data, FWD ? 32'd1 : 32'd0);
        applyStimulus(0, 0, 0, 1, 32'h23);
        checkOutput("t3_hit_two", 32'(ld_hit), 32'(FWD));
        checkOutput("t3_data_two", ld_data, FWD ? 32'd2 : 32'd0);
        ld_addr = 32'h24;
        #1;
        checkOutput("t3_miss_hit", 32'(ld_hit), 32'd0);
        checkOutput("t3_miss_data", ld_data, 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h20);
        checkOutput("t3_drain_wd", dm_wd, 32'd1);
        checkOutput("t3_drain_hit", 32'(ld_hit), 32'(FWD));
        checkOutput("t3_drain_data", ld_data, FWD ? 32'd2 : 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h20);
        checkOutput("t3_head_wd", dm_wd, 32'd2);
        checkOutput("t3_head_hit", 32'(ld_hit), 32'(FWD));
        checkOutput("t3_head_data", ld_data, FWD ? 32'd2 : 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h20);
        checkOutput("t3_empty", 32'(empty), 32'd1);
        checkOutput("t3_hit_after", 32'(ld_hit), 32'd0);

        // Full buffer: no same-cycle bypass, then push+pop keeps count
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h200 + 32'(4 * i), 32'h200 + 32'(i), 1, 0);
        applyStimulus(1, 32'h300, 32'h300, 0, 0);
        checkOutput("t4_st_ready_full", 32'(st_ready), 32'd0);
        checkOutput("t4_full", 32'(full), 32'd1);
        checkOutput("t4_dm_we", 32'(dm_we), 32'd1);
        checkOutput("t4_dm_addr0", dm_addr, 32'h200);
        applyStimulus(1, 32'h300, 32'h300, 0, 0);
        checkOutput("t4_st_ready_3", 32'(st_ready), 32'd1);
        checkOutput("t4_dm_addr1", dm_addr, 32'h204);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_full_after", 32'(full), 32'd0);
        checkOutput("t4_dm_addr2", dm_addr, 32'h208);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_dm_addr3", dm_addr, 32'h20C);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_dm_addr4", dm_addr, 32'h300);
        checkOutput("t4_dm_wd4", dm_wd, 32'h300);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4_empty", 32'(empty), 32'd1);

        // Reset pulsed between edges discards pending stores
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h400 + 32'(4 * i), 32'h400 + 32'(i), 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t5_pending", 32'(empty), 32'd0);
        dm_stall = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("t5_empty_now", 32'(empty), 32'd1);
        checkOutput("t5_dm_we_now", 32'(dm_we), 32'd0);
        checkOutput("t5_dm_addr_now", dm_addr, 32'd0);
        checkOutput("t5_full_now", 32'(full), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("t5_no_write_%0d", i), 32'(dm_we), 32'd0);
        end
        applyStimulus(1, 32'h500, 32'h55, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5_restart_addr", dm_addr, 32'h500);
        checkOutput("t5_restart_wd", dm_wd, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
